// File: rtl/idu_lsu_iq_if.sv
// Dispatch, writeback-wakeup and issue signals between IDU dispatch, the LSU
// issue queue and the LSU execute pipe.
interface idu_lsu_iq_if;
  logic        rtu_global_flush;
  logic        dis_lsu_vld;
  logic [4:0]  dis_lsu_iid;
  logic [6:0]  dis_lsu_opcode;
  logic [6:0]  dis_lsu_funct7;
  logic [2:0]  dis_lsu_funct3;
  logic [63:0] dis_lsu_pc;
  logic        dis_lsu_psrc1_vld;
  logic [5:0]  dis_lsu_psrc1_preg;
  logic        dis_lsu_psrc1_rdy;
  logic [63:0] dis_lsu_psrc1_value;
  logic        dis_lsu_psrc2_vld;
  logic [5:0]  dis_lsu_psrc2_preg;
  logic        dis_lsu_psrc2_rdy;
  logic [63:0] dis_lsu_psrc2_value;
  logic        dis_lsu_pdst_vld;
  logic [5:0]  dis_lsu_pdst;
  logic        dis_lsu_imm_vld;
  logic [63:0] dis_lsu_imm;
  logic        lsu_iq_dis_full;
  logic        exu_idu_rf_alu_wb_vld;
  logic [5:0]  exu_idu_rf_alu_wb_preg;
  logic [63:0] exu_idu_rf_alu_wb_data;
  logic        exu_idu_rf_lsu_wb_vld;
  logic [5:0]  exu_idu_rf_lsu_wb_preg;
  logic [63:0] exu_idu_rf_lsu_wb_data;
  logic        idu_exu_lsu_vld;
  logic [4:0]  idu_exu_lsu_iid;
  logic [6:0]  idu_exu_lsu_opcode;
  logic [6:0]  idu_exu_lsu_funct7;
  logic [2:0]  idu_exu_lsu_funct3;
  logic [63:0] idu_exu_lsu_pc;
  logic        idu_exu_lsu_psrc1_vld;
  logic [63:0] idu_exu_lsu_psrc1_value;
  logic        idu_exu_lsu_psrc2_vld;
  logic [63:0] idu_exu_lsu_psrc2_value;
  logic        idu_exu_lsu_pdst_vld;
  logic [5:0]  idu_exu_lsu_pdst;
  logic        idu_exu_lsu_imm_vld;
  logic [63:0] idu_exu_lsu_imm;

  modport slave (
    input  rtu_global_flush, dis_lsu_vld, dis_lsu_iid, dis_lsu_opcode, dis_lsu_funct7,
           dis_lsu_funct3, dis_lsu_pc, dis_lsu_psrc1_vld, dis_lsu_psrc1_preg,
           dis_lsu_psrc1_rdy, dis_lsu_psrc1_value, dis_lsu_psrc2_vld, dis_lsu_psrc2_preg,
           dis_lsu_psrc2_rdy, dis_lsu_psrc2_value, dis_lsu_pdst_vld, dis_lsu_pdst,
           dis_lsu_imm_vld, dis_lsu_imm,
           exu_idu_rf_alu_wb_vld, exu_idu_rf_alu_wb_preg, exu_idu_rf_alu_wb_data,
           exu_idu_rf_lsu_wb_vld, exu_idu_rf_lsu_wb_preg, exu_idu_rf_lsu_wb_data,
    output lsu_iq_dis_full, idu_exu_lsu_vld, idu_exu_lsu_iid, idu_exu_lsu_opcode,
           idu_exu_lsu_funct7, idu_exu_lsu_funct3, idu_exu_lsu_pc,
           idu_exu_lsu_psrc1_vld, idu_exu_lsu_psrc1_value, idu_exu_lsu_psrc2_vld,
           idu_exu_lsu_psrc2_value, idu_exu_lsu_pdst_vld, idu_exu_lsu_pdst,
           idu_exu_lsu_imm_vld, idu_exu_lsu_imm
  );

  modport master (
    output rtu_global_flush, dis_lsu_vld, dis_lsu_iid, dis_lsu_opcode, dis_lsu_funct7,
           dis_lsu_funct3, dis_lsu_pc, dis_lsu_psrc1_vld, dis_lsu_psrc1_preg,
           dis_lsu_psrc1_rdy, dis_lsu_psrc1_value, dis_lsu_psrc2_vld, dis_lsu_psrc2_preg,
           dis_lsu_psrc2_rdy, dis_lsu_psrc2_value, dis_lsu_pdst_vld, dis_lsu_pdst,
           dis_lsu_imm_vld, dis_lsu_imm,
           exu_idu_rf_alu_wb_vld, exu_idu_rf_alu_wb_preg, exu_idu_rf_alu_wb_data,
           exu_idu_rf_lsu_wb_vld, exu_idu_rf_lsu_wb_preg, exu_idu_rf_lsu_wb_data,
    input  lsu_iq_dis_full, idu_exu_lsu_vld, idu_exu_lsu_iid, idu_exu_lsu_opcode,
           idu_exu_lsu_funct7, idu_exu_lsu_funct3, idu_exu_lsu_pc,
           idu_exu_lsu_psrc1_vld, idu_exu_lsu_psrc1_value, idu_exu_lsu_psrc2_vld,
           idu_exu_lsu_psrc2_value, idu_exu_lsu_pdst_vld, idu_exu_lsu_pdst,
           idu_exu_lsu_imm_vld, idu_exu_lsu_imm
  );
endinterface

// File: rtl/idu_lsu_iq.sv
// In-order LSU issue queue: circular buffer of dispatched loads/stores whose
// sources wake up from the ALU/LSU writeback buses; only the head may issue.
module idu_lsu_iq #(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst_clk,
  idu_lsu_iq_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        vld;
    logic [5:0]  preg;
    logic        rdy;
    logic [63:0] val;
  } src_t;

  typedef struct packed {
    logic [4:0]  iid;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [63:0] pc;
    src_t        s1;
    src_t        s2;
    logic        pdst_vld;
    logic [5:0]  pdst;
    logic        imm_vld;
    logic [63:0] imm;
  } ent_t;

  ent_t            ent_q [DEPTH];
  ent_t            ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full, push, issue;
  ent_t            head, dis_ent;

  // ALU writeback wins when both buses carry the same tag.
  function automatic src_t wake(input src_t s,
                                input logic av, input logic [5:0] ap, input logic [63:0] ad,
                                input logic lv, input logic [5:0] lp, input logic [63:0] ld);
    src_t r;
    r = s;
    if (s.vld && !s.rdy) begin
      if (av && ap == s.preg) begin
        r.rdy = 1'b1;
        r.val = ad;
      end else if (lv && lp == s.preg) begin
        r.rdy = 1'b1;
        r.val = ld;
      end
    end
    return r;
  endfunction

  function automatic logic src_ok(input src_t s);
    return !s.vld || s.rdy;
  endfunction

  always_comb begin
    full  = (cnt_q == CW'(DEPTH));
    head  = ent_q[rd_ptr_q];
    issue = vld_q[rd_ptr_q] && src_ok(head.s1) && src_ok(head.s2) && !bus.rtu_global_flush;
    push  = bus.dis_lsu_vld && !full && !bus.rtu_global_flush;

    dis_ent = '{iid: bus.dis_lsu_iid, opcode: bus.dis_lsu_opcode, funct7: bus.dis_lsu_funct7,
                funct3: bus.dis_lsu_funct3, pc: bus.dis_lsu_pc,
                s1: '{bus.dis_lsu_psrc1_vld, bus.dis_lsu_psrc1_preg, bus.dis_lsu_psrc1_rdy,
                      bus.dis_lsu_psrc1_value},
                s2: '{bus.dis_lsu_psrc2_vld, bus.dis_lsu_psrc2_preg, bus.dis_lsu_psrc2_rdy,
                      bus.dis_lsu_psrc2_value},
                pdst_vld: bus.dis_lsu_pdst_vld, pdst: bus.dis_lsu_pdst,
                imm_vld: bus.dis_lsu_imm_vld, imm: bus.dis_lsu_imm};

    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) begin
        ent_d[i].s1 = wake(ent_q[i].s1, bus.exu_idu_rf_alu_wb_vld, bus.exu_idu_rf_alu_wb_preg,
                           bus.exu_idu_rf_alu_wb_data, bus.exu_idu_rf_lsu_wb_vld,
                           bus.exu_idu_rf_lsu_wb_preg, bus.exu_idu_rf_lsu_wb_data);
        ent_d[i].s2 = wake(ent_q[i].s2, bus.exu_idu_rf_alu_wb_vld, bus.exu_idu_rf_alu_wb_preg,
                           bus.exu_idu_rf_alu_wb_data, bus.exu_idu_rf_lsu_wb_vld,
                           bus.exu_idu_rf_lsu_wb_preg, bus.exu_idu_rf_lsu_wb_data);
      end
    end
    // Same-cycle wakeup of a dispatching entry is captured here.
    if (push) begin
      ent_d[wr_ptr_q]    = dis_ent;
      ent_d[wr_ptr_q].s1 = wake(dis_ent.s1, bus.exu_idu_rf_alu_wb_vld, bus.exu_idu_rf_alu_wb_preg,
                                bus.exu_idu_rf_alu_wb_data, bus.exu_idu_rf_lsu_wb_vld,
                                bus.exu_idu_rf_lsu_wb_preg, bus.exu_idu_rf_lsu_wb_data);
      ent_d[wr_ptr_q].s2 = wake(dis_ent.s2, bus.exu_idu_rf_alu_wb_vld, bus.exu_idu_rf_alu_wb_preg,
                                bus.exu_idu_rf_alu_wb_data, bus.exu_idu_rf_lsu_wb_vld,
                                bus.exu_idu_rf_lsu_wb_preg, bus.exu_idu_rf_lsu_wb_data);
    end

    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (issue) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = PW'(rd_ptr_q + 1'b1);
    end
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = PW'(wr_ptr_q + 1'b1);
    end
    case ({push, issue})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (bus.rtu_global_flush) begin
      vld_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_clk) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign bus.lsu_iq_dis_full         = full;
  assign bus.idu_exu_lsu_vld         = issue;
  assign bus.idu_exu_lsu_iid         = issue ? head.iid : '0;
  assign bus.idu_exu_lsu_opcode      = issue ? head.opcode : '0;
  assign bus.idu_exu_lsu_funct7      = issue ? head.funct7 : '0;
  assign bus.idu_exu_lsu_funct3      = issue ? head.funct3 : '0;
  assign bus.idu_exu_lsu_pc          = issue ? head.pc : '0;
  assign bus.idu_exu_lsu_psrc1_vld   = issue && head.s1.vld;
  assign bus.idu_exu_lsu_psrc1_value = (issue && head.s1.vld) ? head.s1.val : '0;
  assign bus.idu_exu_lsu_psrc2_vld   = issue && head.s2.vld;
  assign bus.idu_exu_lsu_psrc2_value = (issue && head.s2.vld) ? head.s2.val : '0;
  assign bus.idu_exu_lsu_pdst_vld    = issue && head.pdst_vld;
  assign bus.idu_exu_lsu_pdst        = issue ? head.pdst : '0;
  assign bus.idu_exu_lsu_imm_vld     = issue && head.imm_vld;
  assign bus.idu_exu_lsu_imm         = issue ? head.imm : '0;
endmodule

// File: tb/tb_idu_lsu_iq.sv
// Bench for idu_lsu_iq: scenario tasks drive dispatch/wakeup/flush and push the
// expected issue stream; a negedge monitor pops and compares every issue.
module tb_idu_lsu_iq;
  logic clk = 1'b0;
  logic rst_clk = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [4:0]  iid;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] imm;
    logic [63:0] pc;
  } exp_t;

  exp_t sb[$];

  idu_lsu_iq_if bus();
  idu_lsu_iq #(.DEPTH(4)) dut (.clk(clk), .rst_clk(rst_clk), .bus(bus.slave));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_clk) begin
      if (bus.idu_exu_lsu_vld) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: got iid=%0d, required no issue", bus.idu_exu_lsu_iid);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (bus.idu_exu_lsu_iid !== e.iid || bus.idu_exu_lsu_psrc1_value !== e.s1 ||
              bus.idu_exu_lsu_psrc2_value !== e.s2 || bus.idu_exu_lsu_imm !== e.imm ||
              bus.idu_exu_lsu_pc !== e.pc || bus.idu_exu_lsu_pdst !== 6'(e.iid)) begin
            errors++;
            $display("FAIL issue_data: got iid=%0d s1=%h s2=%h imm=%h pc=%h pdst=%0d, required iid=%0d s1=%h s2=%h imm=%h pc=%h",
                     bus.idu_exu_lsu_iid, bus.idu_exu_lsu_psrc1_value, bus.idu_exu_lsu_psrc2_value,
                     bus.idu_exu_lsu_imm, bus.idu_exu_lsu_pc, bus.idu_exu_lsu_pdst,
                     e.iid, e.s1, e.s2, e.imm, e.pc);
          end
        end
      end else begin
        checks++;
        if ({bus.idu_exu_lsu_iid, bus.idu_exu_lsu_opcode, bus.idu_exu_lsu_funct7,
             bus.idu_exu_lsu_funct3, bus.idu_exu_lsu_pc, bus.idu_exu_lsu_psrc1_vld,
             bus.idu_exu_lsu_psrc1_value, bus.idu_exu_lsu_psrc2_vld, bus.idu_exu_lsu_psrc2_value,
             bus.idu_exu_lsu_pdst_vld, bus.idu_exu_lsu_pdst, bus.idu_exu_lsu_imm_vld,
             bus.idu_exu_lsu_imm} !== '0) begin
          errors++;
          $display("FAIL idle_zero: data outputs nonzero with vld=0 (iid=%0d imm=%h s1=%h), required all 0",
                   bus.idu_exu_lsu_iid, bus.idu_exu_lsu_imm, bus.idu_exu_lsu_psrc1_value);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rtu_global_flush       = 1'b0;
    bus.dis_lsu_vld            = 1'b0;
    bus.exu_idu_rf_alu_wb_vld  = 1'b0;
    bus.exu_idu_rf_alu_wb_preg = '0;
    bus.exu_idu_rf_alu_wb_data = '0;
    bus.exu_idu_rf_lsu_wb_vld  = 1'b0;
    bus.exu_idu_rf_lsu_wb_preg = '0;
    bus.exu_idu_rf_lsu_wb_data = '0;
  endtask

  task automatic dispatch(input logic [4:0] iid,
                          input logic s1v, input logic [5:0] s1p, input logic s1r, input logic [63:0] s1d,
                          input logic s2v, input logic [5:0] s2p, input logic s2r, input logic [63:0] s2d,
                          input logic [63:0] imm);
    bus.dis_lsu_vld         = 1'b1;
    bus.dis_lsu_iid         = iid;
    bus.dis_lsu_opcode      = 7'h23;
    bus.dis_lsu_funct7      = 7'h00;
    bus.dis_lsu_funct3      = 3'd3;
    bus.dis_lsu_pc          = 64'(iid) * 4;
    bus.dis_lsu_psrc1_vld   = s1v;
    bus.dis_lsu_psrc1_preg  = s1p;
    bus.dis_lsu_psrc1_rdy   = s1r;
    bus.dis_lsu_psrc1_value = s1d;
    bus.dis_lsu_psrc2_vld   = s2v;
    bus.dis_lsu_psrc2_preg  = s2p;
    bus.dis_lsu_psrc2_rdy   = s2r;
    bus.dis_lsu_psrc2_value = s2d;
    bus.dis_lsu_pdst_vld    = 1'b1;
    bus.dis_lsu_pdst        = 6'(iid);
    bus.dis_lsu_imm_vld     = 1'b1;
    bus.dis_lsu_imm         = imm;
  endtask

  function automatic exp_t mk(input logic [4:0] iid, input logic [63:0] s1,
                              input logic [63:0] s2, input logic [63:0] imm);
    exp_t e;
    e.iid = iid; e.s1 = s1; e.s2 = s2; e.imm = imm; e.pc = 64'(iid) * 4;
    return e;
  endfunction

  task automatic test_reset();
    rst_clk = 1'b1;
    dispatch(5'd1, 1'b1, 6'd1, 1'b1, 64'h11, 1'b0, 6'd0, 1'b0, 64'h0, 64'h1);
    step();
    step();
    checks++;
    if (bus.idu_exu_lsu_vld !== 1'b0 || bus.lsu_iq_dis_full !== 1'b0 || bus.idu_exu_lsu_imm !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b full=%b imm=%h, required 0/0/0",
               bus.idu_exu_lsu_vld, bus.lsu_iq_dis_full, bus.idu_exu_lsu_imm);
    end
    idle();
    rst_clk = 1'b0;
    step();
    checks++;
    if (bus.idu_exu_lsu_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: got vld=%b, required 0", bus.idu_exu_lsu_vld);
    end
  endtask

  task automatic test_basic();
    dispatch(5'd3, 1'b1, 6'd1, 1'b1, 64'h1000, 1'b0, 6'd0, 1'b0, 64'hFFFF, 64'd8);
    sb.push_back(mk(5'd3, 64'h1000, 64'h0, 64'd8));
    step();
    idle();
    checks++;
    if (bus.idu_exu_lsu_vld !== 1'b1 || bus.idu_exu_lsu_iid !== 5'd3 ||
        bus.idu_exu_lsu_psrc1_value !== 64'h1000 || bus.idu_exu_lsu_imm !== 64'd8) begin
      errors++;
      $display("FAIL basic_latency: got vld=%b iid=%0d s1=%h imm=%h, required 1/3/1000/8",
               bus.idu_exu_lsu_vld, bus.idu_exu_lsu_iid, bus.idu_exu_lsu_psrc1_value, bus.idu_exu_lsu_imm);
    end
    step();
    checks++;
    if (bus.idu_exu_lsu_vld !== 1'b0 || bus.lsu_iq_dis_full !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: got vld=%b full=%b, required 0/0", bus.idu_exu_lsu_vld, bus.lsu_iq_dis_full);
    end
  endtask

  task automatic test_wakeup_alu();
    dispatch(5'd4, 1'b1, 6'd2, 1'b1, 64'h2000, 1'b1, 6'd12, 1'b0, 64'h1111, 64'd16);
    step();
    idle();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.idu_exu_lsu_vld !== 1'b0) begin
        errors++;
        $display("FAIL wake_wait: cycle %0d got vld=%b, required 0", i, bus.idu_exu_lsu_vld);
      end
      if (i == 0) step();
    end
    bus.exu_idu_rf_alu_wb_vld  = 1'b1;
    bus.exu_idu_rf_alu_wb_preg = 6'd12;
    bus.exu_idu_rf_alu_wb_data = 64'hDEAD;
    bus.exu_idu_rf_lsu_wb_vld  = 1'b1;
    bus.exu_idu_rf_lsu_wb_preg = 6'd12;
    bus.exu_idu_rf_lsu_wb_data = 64'hBEEF;
    sb.push_back(mk(5'd4, 64'h2000, 64'hDEAD, 64'd16));
    step();
    idle();
    checks++;
    if (bus.idu_exu_lsu_vld !== 1'b1 || bus.idu_exu_lsu_psrc2_value !== 64'hDEAD) begin
      errors++;
      $display("FAIL wake_alu: got vld=%b s2=%h, required 1/dead",
               bus.idu_exu_lsu_vld, bus.idu_exu_lsu_psrc2_value);
    end
    step();
  endtask

  task automatic test_bypass();
    dispatch(5'd5, 1'b1, 6'd7, 1'b0, 64'h9999, 1'b0, 6'd0, 1'b0, 64'h0, 64'd0);
    bus.exu_idu_rf_lsu_wb_vld  = 1'b1;
    bus.exu_idu_rf_lsu_wb_preg = 6'd7;
    bus.exu_idu_rf_lsu_wb_data = 64'h55;
    sb.push_back(mk(5'd5, 64'h55, 64'h0, 64'd0));
    step();
    idle();
    checks++;
    if (bus.idu_exu_lsu_vld !== 1'b1 || bus.idu_exu_lsu_psrc1_value !== 64'h55) begin
      errors++;
      $display("FAIL bypass: got vld=%b s1=%h, required 1/55", bus.idu_exu_lsu_vld, bus.idu_exu_lsu_psrc1_value);
    end
    step();
  endtask

  task automatic test_full();
    dispatch(5'd8, 1'b1, 6'd20, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 64'h0, 64'd1);
    sb.push_back(mk(5'd8, 64'h77, 64'h0, 64'd1));
    step();
    for (int k = 9; k <= 11; k++) begin
      dispatch(5'(k), 1'b1, 6'(k), 1'b1, 64'h100 + 64'(k), 1'b0, 6'd0, 1'b0, 64'h0, 64'(k));
      sb.push_back(mk(5'(k), 64'h100 + 64'(k), 64'h0, 64'(k)));
      step();
      checks++;
      if (bus.lsu_iq_dis_full !== (k == 11) || bus.idu_exu_lsu_vld !== 1'b0) begin
        errors++;
        $display("FAIL full_fill: after iid %0d got full=%b vld=%b, required full=%b vld=0",
                 k, bus.lsu_iq_dis_full, bus.idu_exu_lsu_vld, k == 11);
      end
    end
    dispatch(5'd12, 1'b1, 6'd1, 1'b1, 64'h12, 1'b0, 6'd0, 1'b0, 64'h0, 64'd12);
    step();
    idle();
    bus.exu_idu_rf_alu_wb_vld  = 1'b1;
    bus.exu_idu_rf_alu_wb_preg = 6'd20;
    bus.exu_idu_rf_alu_wb_data = 64'h77;
    step();
    idle();
    checks++;
    if (bus.idu_exu_lsu_vld !== 1'b1 || bus.idu_exu_lsu_iid !== 5'd8 || bus.lsu_iq_dis_full !== 1'b1) begin
      errors++;
      $display("FAIL full_head_wake: got vld=%b iid=%0d full=%b, required 1/8/1",
               bus.idu_exu_lsu_vld, bus.idu_exu_lsu_iid, bus.lsu_iq_dis_full);
    end
    // full with a pop in the same cycle must still refuse this dispatch
    dispatch(5'd13, 1'b1, 6'd1, 1'b1, 64'h13, 1'b0, 6'd0, 1'b0, 64'h0, 64'd13);
    step();
    idle();
    for (int k = 9; k <= 11; k++) begin
      checks++;
      if (bus.idu_exu_lsu_vld !== 1'b1 || bus.idu_exu_lsu_iid !== 5'(k) || bus.lsu_iq_dis_full !== 1'b0) begin
        errors++;
        $display("FAIL full_order: got vld=%b iid=%0d full=%b, required 1/%0d/0",
                 bus.idu_exu_lsu_vld, bus.idu_exu_lsu_iid, bus.lsu_iq_dis_full, k);
      end
      step();
    end
    checks++;
    if (bus.idu_exu_lsu_vld !== 1'b0) begin
      errors++;
      $display("FAIL full_dropped: got vld=%b iid=%0d, required 0", bus.idu_exu_lsu_vld, bus.idu_exu_lsu_iid);
    end
  endtask

  task automatic test_flush();
    dispatch(5'd14, 1'b1, 6'd30, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 64'h0, 64'd14);
    step();
    dispatch(5'd15, 1'b1, 6'd1, 1'b1, 64'h15, 1'b0, 6'd0, 1'b0, 64'h0, 64'd15);
    step();
    dispatch(5'd16, 1'b1, 6'd1, 1'b1, 64'h16, 1'b0, 6'd0, 1'b0, 64'h0, 64'd16);
    step();
    dispatch(5'd17, 1'b1, 6'd1, 1'b1, 64'h17, 1'b0, 6'd0, 1'b0, 64'h0, 64'd17);
    bus.rtu_global_flush       = 1'b1;
    bus.exu_idu_rf_alu_wb_vld  = 1'b1;
    bus.exu_idu_rf_alu_wb_preg = 6'd30;
    bus.exu_idu_rf_alu_wb_data = 64'h30;
    step();
    idle();
    checks++;
    if (bus.idu_exu_lsu_vld !== 1'b0 || bus.lsu_iq_dis_full !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: got vld=%b full=%b, required 0/0", bus.idu_exu_lsu_vld, bus.lsu_iq_dis_full);
    end
    bus.exu_idu_rf_alu_wb_vld  = 1'b1;
    bus.exu_idu_rf_alu_wb_preg = 6'd30;
    step();
    idle();
    step();
    // count must restart at 0: full only after exactly four new dispatches
    for (int k = 0; k < 4; k++) begin
      dispatch(5'(18 + k), 1'b1, (k == 0) ? 6'd40 : 6'd1, k != 0, 64'h180 + 64'(k),
               1'b0, 6'd0, 1'b0, 64'h0, 64'(k));
      sb.push_back(mk(5'(18 + k), (k == 0) ? 64'h40 : 64'h180 + 64'(k), 64'h0, 64'(k)));
      step();
      checks++;
      if (bus.lsu_iq_dis_full !== (k == 3)) begin
        errors++;
        $display("FAIL flush_count: after %0d dispatches got full=%b, required %b",
                 k + 1, bus.lsu_iq_dis_full, k == 3);
      end
    end
    idle();
    bus.exu_idu_rf_alu_wb_vld  = 1'b1;
    bus.exu_idu_rf_alu_wb_preg = 6'd40;
    bus.exu_idu_rf_alu_wb_data = 64'h40;
    step();
    idle();
    repeat (5) step();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      dispatch(5'(i), 1'b1, 6'd2, 1'b1, a, 1'b1, 6'd3, 1'b1, b, 64'(i) + 64'h40);
      sb.push_back(mk(5'(i), a, b, 64'(i) + 64'h40));
      step();
      checks++;
      if (bus.idu_exu_lsu_vld !== 1'b1 || bus.idu_exu_lsu_iid !== 5'(i)) begin
        errors++;
        $display("FAIL wrap_issue: got vld=%b iid=%0d, required 1/%0d", bus.idu_exu_lsu_vld, bus.idu_exu_lsu_iid, i);
      end
    end
    idle();
    step();
    checks++;
    if (bus.idu_exu_lsu_vld !== 1'b0) begin
      errors++;
      $display("FAIL wrap_dup: got vld=%b iid=%0d, required 0", bus.idu_exu_lsu_vld, bus.idu_exu_lsu_iid);
    end
  endtask

  initial begin
    idle();
    dispatch(5'd0, 1'b0, 6'd0, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 64'h0, 64'h0);
    bus.dis_lsu_vld = 1'b0;
    test_reset();
    test_basic();
    test_wakeup_alu();
    test_bypass();
    test_full();
    test_flush();
    test_wrap();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d expected issues never seen, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/idu_lsu_iq.md
IDU_LSU_IQ -- requirements
Module: idu_lsu_iq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries (power of two, 2..8).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_clk  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port rtu_global_flush  in  1  flush, kills all queued entries.
REQ-005 SHALL have port dis_lsu_vld  in  1  dispatch request for one load/store.
REQ-006 SHALL have port dis_lsu_iid/_opcode/_funct7/_funct3/_pc  in  5/7/7/3/64  ROB id and decoded fields.
REQ-007 SHALL have ports dis_lsu_psrcN_vld/_preg/_rdy/_value, N=1,2  in  1/6/1/64  source used, physical tag, value already available, value.
REQ-008 SHALL have port dis_lsu_pdst_vld/_pdst/_imm_vld/_imm  in  1/6/1/64  destination and immediate.
REQ-009 SHALL have port lsu_iq_dis_full  out  1  queue cannot accept dispatch this cycle.
REQ-010 SHALL have ports exu_idu_rf_alu_wb_vld/_preg/_data and exu_idu_rf_lsu_wb_vld/_preg/_data  in  1/6/64 each  writeback wakeup buses.
REQ-011 SHALL have ports idu_exu_lsu_vld/_iid/_opcode/_funct7/_funct3/_pc  out  1/5/7/7/3/64  issue to LSU.
REQ-012 SHALL have ports idu_exu_lsu_psrcN_vld/_value, _pdst_vld/_pdst, _imm_vld/_imm  out  widths as inputs  issued operands.

Function
REQ-013 SHALL hold DEPTH entries in a circular buffer: wr_ptr, rd_ptr (log2 DEPTH bits, wrap DEPTH-1 -> 0), count (0..DEPTH).
REQ-014 SHALL assert lsu_iq_dis_full when count == DEPTH; full blocks push even if a pop occurs the same cycle.
REQ-015 SHALL write an entry at wr_ptr when dis_lsu_vld && !full && !rtu_global_flush; dis_lsu_vld while full is dropped (dispatcher's responsibility).
REQ-016 SHALL, each cycle, for every valid entry source with psrc_vld && !rdy, set rdy and capture data when a wb bus has vld && preg == psrc_preg; ALU bus has priority if both match.
REQ-017 SHALL apply the same match to sources being written this cycle (dispatch-cycle bypass), so no wakeup is lost.
REQ-018 SHALL treat a source with psrc_vld == 0 as ready; its value is issued as 0.
REQ-019 SHALL issue strictly in order: head entry issues when valid and both sources ready; younger entries never bypass the head.
REQ-020 SHALL drive idu_exu_lsu_* combinationally from the head entry; idu_exu_lsu_vld = head issuable && !rtu_global_flush; rd_ptr advances and count decrements on the same edge.
REQ-021 SHALL force all idu_exu_lsu_* data outputs to 0 when idu_exu_lsu_vld == 0.
REQ-022 SHALL issue at most one entry per cycle; minimum latency dispatch-to-issue is 1 cycle (dispatch edge N, idu_exu_lsu_vld high cycle N+1).
REQ-023 SHALL, on simultaneous push and pop (not full), keep count unchanged and move both pointers.
REQ-024 SHALL, on rtu_global_flush, clear all valid bits, wr_ptr, rd_ptr, count on that edge and ignore that cycle's dispatch and wakeup.
REQ-025 SHALL use an entry's wakeup data, not the dispatch value, when the source became ready by wakeup.

Reset
REQ-026 SHALL, while rst_clk is high at a rising edge, clear all valid bits, pointers and count; outputs then read idu_exu_lsu_vld=0, all data outputs 0, lsu_iq_dis_full=0.
REQ-027 SHALL give reset priority over flush, dispatch and wakeup.
REQ-028 SHALL leave entry payload storage unreset except valid bits.

Verification
REQ-029 SHALL pass: dispatch load iid=3, psrc1 rdy value 0x1000, imm 8 into empty queue -> next cycle idu_exu_lsu_vld=1, iid=3, psrc1_value=0x1000, imm=8; count back to 0.
REQ-030 SHALL pass: dispatch store with psrc2 preg=12 not ready; two cycles later alu wb preg=12 data=0xDEAD -> issue following cycle with psrc2_value=0xDEAD.
REQ-031 SHALL pass: dispatch entry whose psrc1 preg=7 not ready in the same cycle lsu wb preg=7 data=0x55 -> entry issues next cycle with psrc1_value=0x55.
REQ-032 SHALL pass: head blocked on operand, dispatch 3 ready entries -> lsu_iq_dis_full=1 after fourth, fifth dispatch dropped, no younger entry issues until head wakes; then iids issue in dispatch order, one per cycle.
REQ-033 SHALL pass: queue holding 3 entries, rtu_global_flush with concurrent dispatch -> next cycle count=0, idu_exu_lsu_vld=0, dispatched entry absent.
REQ-034 SHALL pass: pointer wrap over 10 back-to-back dispatch/issue pairs -> iids issued in order with no loss or duplication.
